eth_rx_frame_buf: RTL
=====================

# eth_rx_frame_buf

Frame-level receive buffer and scheduler between the RMII MAC receiver byte stream and the downstream packet consumer. Stores each incoming frame in a circular byte RAM and commits it only when it ends cleanly (no error, length in range, space available); otherwise it rolls the write pointer back so no partial frame is ever visible. Committed frames are replayed, FCS stripped, on a valid/ready stream in arrival order.

## Interface
- ADDR_W, 12: byte RAM address width; capacity 2^ADDR_W bytes.
- DESC_AW, 3: descriptor FIFO address width; 2^DESC_AW frames queued.
- MAX_LEN, 1522: maximum stored length in bytes, excluding FCS.
- clk_mac  in  1  MAC clock, 50 MHz; the only clock.
- rst  in  1  asynchronous, active-high reset.
- rx_vld  in  1  input beat valid; no backpressure.
- rx_dat  in  8  input byte; valid on non-eof beats.
- rx_sof  in  1  first byte of frame.
- rx_eof  in  1  end marker beat; carries no data.
- rx_len  in  11  byte count so far; on the eof beat, total bytes including FCS.
- rx_err  in  1  on the eof beat, FCS/PHY error.
- m_vld  out  1  output byte valid.
- m_rdy  in  1  consumer accepts.
- m_dat  out  8  output byte.
- m_sof  out  1  first byte of frame.
- m_eof  out  1  last byte of frame.
- m_len  out  11  stored frame length; held for the whole frame.
- drop_pulse  out  1  one-cycle pulse per dropped frame.
- drop_cnt  out  16  saturating count of dropped frames.

## Operation
- Pointers are ADDR_W+1 bits; used = wr_ptr - rd_ptr; full when used = 2^ADDR_W.
- Write FSM states: W_IDLE, W_RECV, W_DROP.
  - W_IDLE: on an rx_vld&&rx_sof beat, set wr_start = wr_commit, write the byte, go to W_RECV. Non-sof beats are ignored.
  - W_RECV: write each data beat at wr_ptr and increment wr_ptr.
    - Go to W_DROP on either: a byte arriving while full, or byte count > MAX_LEN+4.
  - W_RECV eof beat: commit if all hold: rx_err=0, 5 ≤ rx_len ≤ MAX_LEN+4, descriptor FIFO not full.
    - Commit pushes {wr_start, rx_len-4}, sets wr_commit = wr_ptr-4 and wr_ptr = wr_ptr-4 (FCS bytes freed), then returns to W_IDLE.
    - Otherwise drop.
  - Drop: wr_ptr = wr_commit, drop_pulse = 1, drop_cnt++ (saturate at 16'hFFFF).
    - From W_RECV, a drop returns to W_IDLE. A drop entered on overflow/overlength goes to W_DROP.
  - W_DROP: ignore beats until the eof beat, then return to W_IDLE. No second pulse is issued for the same frame.
  - sof while in W_RECV or W_DROP: the current frame is abandoned. If in W_RECV, it is dropped with one pulse. The new frame then starts as from W_IDLE in the same cycle.
- Read FSM states: R_IDLE, R_FETCH, R_SEND.
  - R_IDLE: when the descriptor FIFO is non-empty, load rd_ptr = desc.start and m_len = desc.len, issue the RAM read, go to R_FETCH.
  - R_FETCH: register the byte, assert m_vld with m_sof, go to R_SEND.
  - R_SEND: each accepted beat (m_vld&&m_rdy) advances with a prefetched read, so there are no bubbles while m_rdy stays high.
  - m_eof is asserted on byte m_len-1. Accepting it pops the descriptor and returns to R_IDLE.
- Space is freed byte-wise as rd_ptr advances.
- A simultaneous commit and pop leaves the descriptor count unchanged, and both pointer updates apply.

## Timing
- All outputs are registered.
- Reset value of every output and state: all outputs 0, pointers 0, counters 0, both FSMs idle.
- Reset mid-frame discards all buffered and partial frames.
- Latency: eof beat sampled at edge N with the FIFO previously empty → m_vld=1 with m_sof=1 after edge N+2.
- Drop decision: drop_pulse is high in the cycle after the deciding beat.
- While m_vld&&!m_rdy, m_dat, m_sof, m_eof and m_len hold stable.
- m_vld never deasserts mid-frame.
- Gap between frames: at most 2 idle cycles with m_rdy held high.
- A frame whose length exactly equals the free space is accepted. A frame one byte larger is dropped.

## Structure
- Shared package eth_pkg holds: ETH_FCS_LEN=4, ETH_MAX_LEN=1522, and typedef eth_desc_t {start[ADDR_W-1:0], len[10:0]}.
- Sub-module eth_rx_buf_ram: simple dual-port RAM, one write port, one synchronous-read port (1-cycle latency), inferred BRAM.
- The descriptor FIFO is inline registers.

## Test plan
- 64-byte good frame (rx_len=68 at eof), m_rdy=1 → 64 bytes out, m_len=64, m_sof on byte 0, m_eof on byte 63, m_vld after edge N+2, drop_cnt=0.
- Same frame with rx_err=1 → no output, one drop_pulse, drop_cnt=1, used=0.
- ADDR_W=8, back-to-back 200- and 100-byte frames, m_rdy=0 → first stored, second overflows and is dropped. Then m_rdy=1 → only the 200-byte frame emerges.
- 9 good frames with DESC_AW=3, m_rdy=0 → the 9th is dropped, 8 frames are then read in order.
- 1600-byte frame → W_DROP, one pulse, following good frame intact. Random m_rdy gaps → data matches byte-for-byte.
- sof reissued mid-frame, and rst asserted mid-frame → the abandoned frame is dropped or flushed, the next frame is correct, all outputs are 0 during reset.

Source files
------------

// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared constants, descriptor type and FSM state types for the Ethernet RX frame buffer
//
// Purpose: constants and types shared by eth_rx_frame_buf and its sub-modules.
// Contents: ETH_FCS_LEN, ETH_MAX_LEN, ETH_ADDR_W, eth_desc_t, w_state_t, r_state_t.
package eth_pkg;

  localparam int ETH_FCS_LEN = 4;
  localparam int ETH_MAX_LEN = 1522;
  // Byte-RAM address width the descriptor start field is sized for.
  localparam int ETH_ADDR_W  = 12;

  // One committed frame: RAM start address and stored length (FCS excluded).
  typedef struct packed {
    logic [ETH_ADDR_W-1:0] start;
    logic [10:0]           len;
  } eth_desc_t;

  typedef enum logic [1:0] {W_IDLE, W_RECV, W_DROP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_SEND} r_state_t;

endpackage

// File: rtl/eth_rx_buf_ram.sv
// rtl/eth_rx_buf_ram.sv - simple dual-port byte RAM, one write port and one registered read port
//
// Purpose: frame byte storage, written by the receive side and read by the replay side.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write byte
//   raddr  in   read address, sampled every cycle
//   rdata  out  byte at raddr from the previous cycle (1-cycle latency)
module eth_rx_buf_ram #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [2**AW];

  // No reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/eth_rx_frame_buf.sv
// rtl/eth_rx_frame_buf.sv - frame-level RX buffer: commit/rollback store and in-order FCS-stripped replay
//
// Purpose: stores MAC receive frames in a circular byte RAM, commits clean frames to a
// descriptor FIFO, rolls back bad ones, and replays committed frames on a valid/ready stream.
// Ports:
//   clk_mac, rst                       clock, asynchronous active-high reset
//   rx_vld/rx_dat/rx_sof/rx_eof        MAC byte stream (eof beat carries no data)
//   rx_len/rx_err                      byte count / error flag (meaningful on the eof beat)
//   m_vld/m_rdy/m_dat/m_sof/m_eof      output byte stream
//   m_len                              stored frame length, held for the whole frame
//   drop_pulse/drop_cnt                per-drop pulse and saturating drop counter
module eth_rx_frame_buf
  import eth_pkg::*;
#(
  parameter int ADDR_W  = ETH_ADDR_W,
  parameter int DESC_AW = 3,
  parameter int MAX_LEN = ETH_MAX_LEN
) (
  input  logic        clk_mac,
  input  logic        rst,
  input  logic        rx_vld,
  input  logic [7:0]  rx_dat,
  input  logic        rx_sof,
  input  logic        rx_eof,
  input  logic [10:0] rx_len,
  input  logic        rx_err,
  output logic        m_vld,
  input  logic        m_rdy,
  output logic [7:0]  m_dat,
  output logic        m_sof,
  output logic        m_eof,
  output logic [10:0] m_len,
  output logic        drop_pulse,
  output logic [15:0] drop_cnt
);

  localparam int PW    = ADDR_W + 1;
  localparam int DEPTH = 1 << DESC_AW;
  localparam logic [11:0]       MAX_TOT = 12'(MAX_LEN + ETH_FCS_LEN);
  localparam logic [10:0]       MIN_TOT = 11'(ETH_FCS_LEN + 1);
  localparam logic [10:0]       FCS_L   = 11'(ETH_FCS_LEN);
  localparam logic [PW-1:0]     P_ONE   = PW'(1);
  localparam logic [PW-1:0]     P_FCS   = PW'(ETH_FCS_LEN);
  localparam logic [ADDR_W-1:0] A_ONE   = ADDR_W'(1);

  // Write side state
  w_state_t          w_st_q, w_st_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     wr_commit_q, wr_commit_d;
  logic [ADDR_W-1:0] wr_start_q, wr_start_d;
  logic [11:0]       cnt_q, cnt_d;
  logic              drop_pulse_q, drop_pulse_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;

  // Read side state
  r_state_t          r_st_q, r_st_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] nxt_q, nxt_d;
  logic [10:0]       idx_q, idx_d;
  logic              m_vld_q, m_vld_d;
  logic [7:0]        m_dat_q, m_dat_d;
  logic              m_sof_q, m_sof_d;
  logic              m_eof_q, m_eof_d;
  logic [10:0]       m_len_q, m_len_d;

  // Descriptor FIFO
  eth_desc_t         desc_mem_q [DEPTH];
  logic [DESC_AW-1:0] desc_wr_q, desc_wr_d;
  logic [DESC_AW-1:0] desc_rd_q, desc_rd_d;
  logic [DESC_AW:0]   desc_cnt_q, desc_cnt_d;
  eth_desc_t         push_desc, head;
  logic              push, pop, drop_evt;

  // RAM ports
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr, ram_raddr;
  logic [7:0]        ram_rdata;

  logic [PW-1:0]     used, used_commit;
  logic              full, full_commit, desc_full, commit_ok;

  // used never exceeds 2^ADDR_W, so its top bit alone flags "full".
  assign used        = wr_ptr_q - rd_ptr_q;
  assign used_commit = wr_commit_q - rd_ptr_q;
  assign full        = used[ADDR_W];
  assign full_commit = used_commit[ADDR_W];
  assign desc_full   = desc_cnt_q[DESC_AW];
  assign head        = desc_mem_q[desc_rd_q];
  assign commit_ok   = !rx_err && (rx_len >= MIN_TOT) && ({1'b0, rx_len} <= MAX_TOT) && !desc_full;

  eth_rx_buf_ram #(.AW(ADDR_W)) u_ram (
    .clk   (clk_mac),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (rx_dat),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // Write FSM
  always_comb begin
    w_st_d       = w_st_q;
    wr_ptr_d     = wr_ptr_q;
    wr_commit_d  = wr_commit_q;
    wr_start_d   = wr_start_q;
    cnt_d        = cnt_q;
    drop_pulse_d = 1'b0;
    drop_cnt_d   = drop_cnt_q;
    ram_we       = 1'b0;
    ram_waddr    = wr_ptr_q[ADDR_W-1:0];
    push         = 1'b0;
    drop_evt     = 1'b0;
    push_desc.start = ETH_ADDR_W'(wr_start_q);
    push_desc.len   = rx_len - FCS_L;

    if (rx_vld) begin
      if (rx_sof && !rx_eof) begin
        // A new frame always restarts from the last committed point; any
        // half-received frame is abandoned (and counted if it was live).
        if (w_st_q == W_RECV) drop_evt = 1'b1;
        wr_start_d = wr_commit_q[ADDR_W-1:0];
        cnt_d      = 12'd1;
        if (full_commit) begin
          drop_evt = 1'b1;
          wr_ptr_d = wr_commit_q;
          w_st_d   = W_DROP;
        end else begin
          ram_we    = 1'b1;
          ram_waddr = wr_commit_q[ADDR_W-1:0];
          wr_ptr_d  = wr_commit_q + P_ONE;
          w_st_d    = W_RECV;
        end
      end else if (w_st_q == W_RECV) begin
        if (rx_eof) begin
          w_st_d = W_IDLE;
          if (commit_ok) begin
            // The trailing FCS bytes were stored; back the pointer over them.
            push        = 1'b1;
            wr_ptr_d    = wr_ptr_q - P_FCS;
            wr_commit_d = wr_ptr_q - P_FCS;
          end else begin
            drop_evt = 1'b1;
            wr_ptr_d = wr_commit_q;
          end
        end else if (full || cnt_q >= MAX_TOT) begin
          drop_evt = 1'b1;
          wr_ptr_d = wr_commit_q;
          w_st_d   = W_DROP;
        end else begin
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + P_ONE;
          cnt_d    = cnt_q + 12'd1;
        end
      end else if (w_st_q == W_DROP && rx_eof) begin
        w_st_d = W_IDLE;
      end
    end

    if (drop_evt) begin
      drop_pulse_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // Read FSM. nxt_q is the address the RAM is fetching for the beat after the
  // one on m_dat; during a stall the previous address is re-read so rdata holds.
  always_comb begin
    r_st_d    = r_st_q;
    rd_ptr_d  = rd_ptr_q;
    nxt_d     = nxt_q;
    idx_d     = idx_q;
    m_vld_d   = m_vld_q;
    m_dat_d   = m_dat_q;
    m_sof_d   = m_sof_q;
    m_eof_d   = m_eof_q;
    m_len_d   = m_len_q;
    ram_raddr = nxt_q;
    pop       = 1'b0;

    case (r_st_q)
      R_IDLE: begin
        // Frames are stored back to back, so rd_ptr already sits at head.start.
        if (desc_cnt_q != '0) begin
          ram_raddr = ADDR_W'(head.start);
          nxt_d     = ADDR_W'(head.start) + A_ONE;
          m_len_d   = head.len;
          r_st_d    = R_FETCH;
        end
      end
      R_FETCH: begin
        ram_raddr = nxt_q;
        nxt_d     = nxt_q + A_ONE;
        m_dat_d   = ram_rdata;
        m_vld_d   = 1'b1;
        m_sof_d   = 1'b1;
        m_eof_d   = (m_len_q == 11'd1);
        idx_d     = 11'd0;
        r_st_d    = R_SEND;
      end
      R_SEND: begin
        if (m_vld_q && m_rdy) begin
          rd_ptr_d  = rd_ptr_q + P_ONE;
          ram_raddr = nxt_q;
          if (m_eof_q) begin
            pop     = 1'b1;
            m_vld_d = 1'b0;
            m_sof_d = 1'b0;
            m_eof_d = 1'b0;
            r_st_d  = R_IDLE;
          end else begin
            nxt_d   = nxt_q + A_ONE;
            m_dat_d = ram_rdata;
            m_sof_d = 1'b0;
            idx_d   = idx_q + 11'd1;
            m_eof_d = ((idx_q + 11'd2) == m_len_q);
          end
        end else begin
          ram_raddr = nxt_q - A_ONE;
        end
      end
      default: r_st_d = R_IDLE;
    endcase
  end

  // Descriptor FIFO bookkeeping; push and pop in one cycle cancel in the count.
  always_comb begin
    desc_wr_d  = push ? desc_wr_q + 1'b1 : desc_wr_q;
    desc_rd_d  = pop  ? desc_rd_q + 1'b1 : desc_rd_q;
    desc_cnt_d = desc_cnt_q;
    if (push && !pop) desc_cnt_d = desc_cnt_q + 1'b1;
    if (pop && !push) desc_cnt_d = desc_cnt_q - 1'b1;
  end

  always_ff @(posedge clk_mac or posedge rst) begin
    if (rst) begin
      w_st_q       <= W_IDLE;
      wr_ptr_q     <= '0;
      wr_commit_q  <= '0;
      wr_start_q   <= '0;
      cnt_q        <= '0;
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= '0;
      r_st_q       <= R_IDLE;
      rd_ptr_q     <= '0;
      nxt_q        <= '0;
      idx_q        <= '0;
      m_vld_q      <= 1'b0;
      m_dat_q      <= '0;
      m_sof_q      <= 1'b0;
      m_eof_q      <= 1'b0;
      m_len_q      <= '0;
      desc_wr_q    <= '0;
      desc_rd_q    <= '0;
      desc_cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) desc_mem_q[i] <= '0;
    end else begin
      w_st_q       <= w_st_d;
      wr_ptr_q     <= wr_ptr_d;
      wr_commit_q  <= wr_commit_d;
      wr_start_q   <= wr_start_d;
      cnt_q        <= cnt_d;
      drop_pulse_q <= drop_pulse_d;
      drop_cnt_q   <= drop_cnt_d;
      r_st_q       <= r_st_d;
      rd_ptr_q     <= rd_ptr_d;
      nxt_q        <= nxt_d;
      idx_q        <= idx_d;
      m_vld_q      <= m_vld_d;
      m_dat_q      <= m_dat_d;
      m_sof_q      <= m_sof_d;
      m_eof_q      <= m_eof_d;
      m_len_q      <= m_len_d;
      desc_wr_q    <= desc_wr_d;
      desc_rd_q    <= desc_rd_d;
      desc_cnt_q   <= desc_cnt_d;
      if (push) desc_mem_q[desc_wr_q] <= push_desc;
    end
  end

  assign m_vld      = m_vld_q;
  assign m_dat      = m_dat_q;
  assign m_sof      = m_sof_q;
  assign m_eof      = m_eof_q;
  assign m_len      = m_len_q;
  assign drop_pulse = drop_pulse_q;
  assign drop_cnt   = drop_cnt_q;

endmodule
